stack_checker: RTL and testbench
================================

// Module: stack_checker
// PURPOSE
//  Consumes the reference stack model's output in lock-step with the CPU's data/return stack and checks it.
//  Observes the same push/pop/in strobes the reference stack sees and tracks depth.
//  After each stack event, compares reference top-read against the DUT's value.
//  Flags overflow/underflow; counts mismatches and captures the first one for debug readout.
// PARAMETERS
//  WIDTH    11  stack word width; must equal the reference stack's WIDTH
//  DEPTH    7   log2 of stack entries; must equal the reference stack's DEPTH
//  CNT_W    16  width of saturating mismatch counter
// PORTS
//  clk            in   1          system clock, all state on rising edge
//  reset          in   1          asynchronous, active-high
//  push           in   1          same strobe driven to reference stack
//  pop            in   1          same strobe driven to reference stack
//  in             in   WIDTH      same data driven to reference stack (captured for debug only)
//  ref_out        in   WIDTH      reference stack read data
//  dut_out        in   WIDTH      DUT stack read data, same timing as ref_out
//  depth          out  DEPTH+1    current tracked depth, 0..2**DEPTH
//  overflow       out  1          sticky: push seen at full depth
//  underflow      out  1          sticky: pop seen at depth 0
//  mismatch       out  1          one-cycle pulse on compare failure
//  err_count      out  CNT_W      saturating mismatch count
//  first_valid    out  1          first-error capture holds data
//  first_exp      out  WIDTH      ref_out at first mismatch
//  first_act      out  WIDTH      dut_out at first mismatch
//  first_depth    out  DEPTH+1    depth before the event that produced first mismatch
// BEHAVIOUR
//  Reset: every output 0; state CHECK; pending 0.
//  Event decode (matches the reference stack): push has priority; push&pop == push.
//  Depth: push -> +1, pop -> -1, else hold; updates on the clock edge of the strobe.
//  Full = depth == 2**DEPTH. push at full -> overflow<=1, depth holds, state -> HALT.
//  Empty = depth == 0. pop (without push) at empty -> underflow<=1, depth holds, state -> HALT.
//  Compare pipeline: on event edge, pend<=1 and pend_depth<=depth (pre-event value).
//  Cycle after event (ref_out freshly updated): if pend && state==CHECK && pend_depth>=1:
//    ref_out != dut_out -> mismatch=1 this cycle (registered pulse, visible one cycle later, i.e. 2 cycles after event edge).
//  pend_depth==0 -> read data is don't-care, no compare.
//  Back-to-back events: pend reloads every cycle; each event compared exactly once.
//  On mismatch: err_count+1, saturating at all-ones.
//  If !first_valid: capture first_exp/act/depth, first_valid<=1; later mismatches do not overwrite.
//  FSM: CHECK (compares enabled) -> HALT on overflow/underflow. HALT absorbing until reset.
//  In HALT: depth frozen, no compares, no new mismatch pulses; err_count/first_* hold.
//  Event on the same edge as the overflow/underflow still sets pend, but its compare is suppressed by HALT.
//  Reset asserted mid-sequence: all state cleared immediately (async).
//  The in-flight pend is discarded; first cycle after deassert behaves as fresh start.
//  The reference stack's own reset is synchronous; the bench holds reset >=1 clock so both agree.
// STRUCTURE
//  Package stack_pkg: WIDTH/DEPTH defaults, state enum {CHECK, HALT}.
//  Package stack_pkg also holds helper constant FULL = 1<<DEPTH.
//  Sub-module sat_counter #(CNT_W) for err_count; everything else flat.
//  No memory: checker never stores stack contents, relies on ref_out.
// TESTING
//  1. push 0x011,0x022,0x033, then pop x3 with dut_out tracking ref_out.
//     Required: depth 1,2,3,2,1,0; mismatch never; err_count 0.
//  2. Depth 2, push 0x055, dut_out=0x7FF vs ref_out=0x011 on compare cycle.
//     Required: mismatch pulse 1 cycle; err_count 1; first_exp 0x011, first_act 0x7FF, first_depth 2.
//  3. Two further mismatches (0x001/0x002).
//     Required: err_count 3; first_* unchanged.
//  4. 128 pushes (DEPTH=7) then one more push.
//     Required: depth 128; overflow 1; state HALT; subsequent mismatches ignored.
//  5. From reset, pop at depth 0.
//     Required: underflow 1, depth 0, no compare.
//     Then assert reset mid-pend: all outputs 0 next cycle; push resumes at depth 1.
//  6. push&pop same cycle at depth 4.
//     Required: depth 5 (push wins).
//     Force err_count to 0xFFFE, inject 3 mismatches: required err_count 0xFFFF.

Source files
------------

// File: rtl/stack_checker_pkg.sv
// Shared definitions for the stack checker.
//   WIDTH_DEF / DEPTH_DEF / CNT_W_DEF : default word width, log2 entries, counter width
//   FULL                              : entry count of a default-sized stack (1 << DEPTH_DEF)
//   state_e                           : checker FSM encoding
//   full_depth()                      : entry count for an arbitrary DEPTH
package stack_pkg;

  localparam int WIDTH_DEF = 11;
  localparam int DEPTH_DEF = 7;
  localparam int CNT_W_DEF = 16;

  localparam int FULL = 1 << DEPTH_DEF;

  // state   | meaning
  // CHECK   | tracking depth, comparing ref_out against dut_out
  // HALT    | overflow/underflow seen; everything frozen until reset
  typedef enum logic [0:0] {
    CHECK = 1'b0,
    HALT  = 1'b1
  } state_e;

  function automatic int full_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/stack_checker_if.sv
// Stack strobe/data bundle shared by the reference stack, the CPU stack and
// the checker.
//   push, pop : stack event strobes
//   in        : data pushed onto the stack
//   ref_out   : reference stack read data
//   dut_out   : CPU stack read data, same timing as ref_out
// master drives the bundle, slave (the checker) only observes it.
interface stack_checker_if #(
  parameter int WIDTH = 11
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] ref_out;
  logic [WIDTH-1:0] dut_out;

  modport master (
    output push,
    output pop,
    output in,
    output ref_out,
    output dut_out
  );

  modport slave (
    input push,
    input pop,
    input in,
    input ref_out,
    input dut_out
  );
endinterface

// File: rtl/stack_checker_sat_counter.sv
// Saturating up-counter.
//   clk, reset : clock and async active-high reset
//   inc        : count one event this cycle
//   count      : current value, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stack_checker.sv
// Lock-step checker for a CPU data/return stack against a reference model.
// Tracks depth from the push/pop strobes, compares ref_out with dut_out the
// cycle after every stack event, flags overflow/underflow and records the
// first mismatch.
//   clk, reset   : clock, async active-high reset
//   bus          : stack strobes and read data (observed only)
//   depth        : tracked depth, 0..2**DEPTH
//   overflow     : sticky, push seen at full depth
//   underflow    : sticky, pop seen at depth 0
//   mismatch     : one-cycle pulse per failed compare
//   err_count    : saturating mismatch count
//   first_valid  : first-mismatch capture is loaded
//   first_exp    : ref_out at first mismatch
//   first_act    : dut_out at first mismatch
//   first_depth  : pre-event depth of the event behind the first mismatch
//   last_in      : data of the most recent accepted push (debug)
module stack_checker
  import stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  stack_checker_if.slave   bus,
  output logic [DEPTH:0]   depth,
  output logic             overflow,
  output logic             underflow,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic             first_valid,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_act,
  output logic [DEPTH:0]   first_depth,
  output logic [WIDTH-1:0] last_in
);

  localparam logic [DEPTH:0] FULL_D = (DEPTH + 1)'(full_depth(DEPTH));

  state_e         state;
  logic           pend;
  logic [DEPTH:0] pend_depth;

  logic ev_push;
  logic ev_pop;
  logic at_full;
  logic at_empty;
  logic cmp_fail;

  // push wins when both strobes are high, same as the reference stack
  always_comb begin
    ev_push  = bus.push;
    ev_pop   = bus.pop & ~bus.push;
    at_full  = (depth == FULL_D);
    at_empty = (depth == '0);
  end

  // A pop from an empty stack or a push onto an empty one leaves read data
  // meaningless, hence the pend_depth guard.
  always_comb begin
    cmp_fail = pend && (state == CHECK) && (pend_depth != '0) &&
               (bus.ref_out != bus.dut_out);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CHECK;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      last_in   <= '0;
    end else if (state == CHECK) begin
      if (ev_push) begin
        if (at_full) begin
          overflow <= 1'b1;
          state    <= HALT;
        end else begin
          depth   <= depth + 1'b1;
          last_in <= bus.in;
        end
      end else if (ev_pop) begin
        if (at_empty) begin
          underflow <= 1'b1;
          state     <= HALT;
        end else begin
          depth <= depth - 1'b1;
        end
      end
    end
  end

  // Reloads every cycle so back-to-back events are each compared once; the
  // event that trips HALT still loads pend but its compare sees HALT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend       <= 1'b0;
      pend_depth <= '0;
    end else begin
      pend       <= ev_push | ev_pop;
      pend_depth <= depth;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch    <= 1'b0;
      first_valid <= 1'b0;
      first_exp   <= '0;
      first_act   <= '0;
      first_depth <= '0;
    end else begin
      mismatch <= cmp_fail;
      if (cmp_fail && !first_valid) begin
        first_valid <= 1'b1;
        first_exp   <= bus.ref_out;
        first_act   <= bus.dut_out;
        first_depth <= pend_depth;
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cmp_fail),
    .count (err_count)
  );

endmodule

// File: tb/tb_stack_checker.sv
module tb_stack_checker;
  import stack_pkg::*;

  logic clk = 1'b0;
  logic reset;

  logic [7:0]  depth;
  logic        overflow;
  logic        underflow;
  logic        mismatch;
  logic [15:0] err_count;
  logic        first_valid;
  logic [10:0] first_exp;
  logic [10:0] first_act;
  logic [7:0]  first_depth;
  logic [10:0] last_in;

  int n_checks = 0;
  int n_fail   = 0;

  stack_checker_if #(.WIDTH(11)) sif ();

  stack_checker #(
    .WIDTH(11),
    .DEPTH(7),
    .CNT_W(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (sif),
    .depth       (depth),
    .overflow    (overflow),
    .underflow   (underflow),
    .mismatch    (mismatch),
    .err_count   (err_count),
    .first_valid (first_valid),
    .first_exp   (first_exp),
    .first_act   (first_act),
    .first_depth (first_depth),
    .last_in     (last_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic        pop;
    logic [10:0] din;
    logic [10:0] r;
    logic [10:0] d;
    logic [7:0]  e_depth;
    logic        e_mm;
    logic [15:0] e_err;
    logic        e_fv;
    logic [10:0] e_fexp;
    logic [10:0] e_fact;
    logic [7:0]  e_fdep;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic pu, input logic po, input logic [10:0] din,
                              input logic [10:0] r, input logic [10:0] d,
                              input logic [7:0] dp, input logic mm, input logic [15:0] er,
                              input logic fv, input logic [10:0] fe, input logic [10:0] fa,
                              input logic [7:0] fd);
    vec_t v;
    v.push = pu; v.pop = po; v.din = din; v.r = r; v.d = d;
    v.e_depth = dp; v.e_mm = mm; v.e_err = er;
    v.e_fv = fv; v.e_fexp = fe; v.e_fact = fa; v.e_fdep = fd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // drive one cycle's inputs just after an edge, then sample after the next edge
  task automatic step(input logic pu, input logic po, input logic [10:0] din,
                      input logic [10:0] r, input logic [10:0] d);
    sif.push = pu; sif.pop = po; sif.in = din; sif.ref_out = r; sif.dut_out = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sif.push = 1'b0; sif.pop = 1'b0; sif.in = '0; sif.ref_out = '0; sif.dut_out = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " depth"},       32'(depth),       32'd0);
    check({tag, " overflow"},    32'(overflow),    32'd0);
    check({tag, " underflow"},   32'(underflow),   32'd0);
    check({tag, " mismatch"},    32'(mismatch),    32'd0);
    check({tag, " err_count"},   32'(err_count),   32'd0);
    check({tag, " first_valid"}, 32'(first_valid), 32'd0);
    check({tag, " first_exp"},   32'(first_exp),   32'd0);
    check({tag, " first_act"},   32'(first_act),   32'd0);
    check({tag, " first_depth"}, 32'(first_depth), 32'd0);
    check({tag, " last_in"},     32'(last_in),     32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // tests 1-3: push/pop tracking, first mismatch, further mismatches
    tbl[0]  = mk(1'b1, 1'b0, 11'h011, 11'h000, 11'h000, 8'd1, 1'b0, 16'd0, 1'b0, 11'h000, 11'h000, 8'd0);
    tbl[1]  = mk(1'b1, 1'b0, 11'h022, 11'h011, 11'h011, 8'd2, 1'b0, 16'd0, 1'b0, 11'h000, 11'h000, 8'd0);
    tbl[2]  = mk(1'b1, 1'b0, 11'h033, 11'h022, 11'h022, 8'd3, 1'b0, 16'd0, 1'b0, 11'h000, 11'h000, 8'd0);
    tbl[3]  = mk(1'b0, 1'b1, 11'h000, 11'h033, 11'h033, 8'd2, 1'b0, 16'd0, 1'b0, 11'h000, 11'h000, 8'd0);
    tbl[4]  = mk(1'b0, 1'b1, 11'h000, 11'h022, 11'h022, 8'd1, 1'b0, 16'd0, 1'b0, 11'h000, 11'h000, 8'd0);
    tbl[5]  = mk(1'b0, 1'b1, 11'h000, 11'h011, 11'h011, 8'd0, 1'b0, 16'd0, 1'b0, 11'h000, 11'h000, 8'd0);
    tbl[6]  = mk(1'b0, 1'b0, 11'h000, 11'h000, 11'h000, 8'd0, 1'b0, 16'd0, 1'b0, 11'h000, 11'h000, 8'd0);
    tbl[7]  = mk(1'b1, 1'b0, 11'h011, 11'h000, 11'h000, 8'd1, 1'b0, 16'd0, 1'b0, 11'h000, 11'h000, 8'd0);
    tbl[8]  = mk(1'b1, 1'b0, 11'h022, 11'h011, 11'h011, 8'd2, 1'b0, 16'd0, 1'b0, 11'h000, 11'h000, 8'd0);
    tbl[9]  = mk(1'b1, 1'b0, 11'h055, 11'h022, 11'h022, 8'd3, 1'b0, 16'd0, 1'b0, 11'h000, 11'h000, 8'd0);
    tbl[10] = mk(1'b0, 1'b0, 11'h000, 11'h011, 11'h7FF, 8'd3, 1'b1, 16'd1, 1'b1, 11'h011, 11'h7FF, 8'd2);
    tbl[11] = mk(1'b0, 1'b0, 11'h000, 11'h055, 11'h000, 8'd3, 1'b0, 16'd1, 1'b1, 11'h011, 11'h7FF, 8'd2);
    tbl[12] = mk(1'b0, 1'b1, 11'h000, 11'h055, 11'h055, 8'd2, 1'b0, 16'd1, 1'b1, 11'h011, 11'h7FF, 8'd2);
    tbl[13] = mk(1'b0, 1'b1, 11'h000, 11'h022, 11'h001, 8'd1, 1'b1, 16'd2, 1'b1, 11'h011, 11'h7FF, 8'd2);
    tbl[14] = mk(1'b0, 1'b0, 11'h000, 11'h011, 11'h002, 8'd1, 1'b1, 16'd3, 1'b1, 11'h011, 11'h7FF, 8'd2);
    tbl[15] = mk(1'b0, 1'b0, 11'h000, 11'h011, 11'h002, 8'd1, 1'b0, 16'd3, 1'b1, 11'h011, 11'h7FF, 8'd2);

    do_reset();
    check_all_zero("reset");
    check("reset state", 32'(dut.state), 32'(CHECK));

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].push, tbl[i].pop, tbl[i].din, tbl[i].r, tbl[i].d);
      check($sformatf("vec%0d depth", i),       32'(depth),       32'(tbl[i].e_depth));
      check($sformatf("vec%0d mismatch", i),    32'(mismatch),    32'(tbl[i].e_mm));
      check($sformatf("vec%0d err_count", i),   32'(err_count),   32'(tbl[i].e_err));
      check($sformatf("vec%0d first_valid", i), 32'(first_valid), 32'(tbl[i].e_fv));
      check($sformatf("vec%0d first_exp", i),   32'(first_exp),   32'(tbl[i].e_fexp));
      check($sformatf("vec%0d first_act", i),   32'(first_act),   32'(tbl[i].e_fact));
      check($sformatf("vec%0d first_depth", i), 32'(first_depth), 32'(tbl[i].e_fdep));
      check($sformatf("vec%0d flags", i),       32'({overflow, underflow}), 32'd0);
      if (i == 2) check("vec2 last_in", 32'(last_in), 32'h033);
    end

    // test 4: fill to 2**DEPTH, then overflow and HALT
    do_reset();
    for (int i = 0; i < 128; i++) step(1'b1, 1'b0, 11'(i), 11'h000, 11'h000);
    check("fill depth", 32'(depth), 32'd128);
    check("fill overflow", 32'(overflow), 32'd0);
    check("fill last_in", 32'(last_in), 32'd127);
    step(1'b1, 1'b0, 11'h7FF, 11'h000, 11'h000);
    check("ovf flag", 32'(overflow), 32'd1);
    check("ovf depth", 32'(depth), 32'd128);
    check("ovf state", 32'(dut.state), 32'(HALT));
    check("ovf last_in", 32'(last_in), 32'd127);
    step(1'b0, 1'b0, 11'h000, 11'h001, 11'h002);
    check("ovf suppressed mm", 32'(mismatch), 32'd0);
    step(1'b0, 1'b1, 11'h000, 11'h001, 11'h002);
    check("halt depth frozen", 32'(depth), 32'd128);
    step(1'b0, 1'b0, 11'h000, 11'h001, 11'h002);
    check("halt mm", 32'(mismatch), 32'd0);
    check("halt err", 32'(err_count), 32'd0);
    check("halt first_valid", 32'(first_valid), 32'd0);

    // test 5: underflow, then async reset with a compare in flight
    do_reset();
    step(1'b0, 1'b1, 11'h000, 11'h000, 11'h000);
    check("unf flag", 32'(underflow), 32'd1);
    check("unf depth", 32'(depth), 32'd0);
    check("unf state", 32'(dut.state), 32'(HALT));
    step(1'b0, 1'b0, 11'h000, 11'h001, 11'h002);
    check("unf no compare", 32'(mismatch), 32'd0);
    check("unf err", 32'(err_count), 32'd0);

    do_reset();
    step(1'b1, 1'b0, 11'h0AA, 11'h000, 11'h000);
    step(1'b1, 1'b0, 11'h0BB, 11'h0AA, 11'h0AA);
    step(1'b0, 1'b0, 11'h000, 11'h001, 11'h002);
    check("pre-rst mm", 32'(mismatch), 32'd1);
    check("pre-rst err", 32'(err_count), 32'd1);
    step(1'b1, 1'b0, 11'h0CC, 11'h0BB, 11'h0BB);
    check("pre-rst depth", 32'(depth), 32'd3);
    sif.push = 1'b0; sif.ref_out = 11'h001; sif.dut_out = 11'h002;
    reset = 1'b1;
    #1;
    check_all_zero("async rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0, 11'h000, 11'h001, 11'h002);
    check("post-rst no mm", 32'(mismatch), 32'd0);
    check("post-rst err", 32'(err_count), 32'd0);
    step(1'b1, 1'b0, 11'h0DD, 11'h001, 11'h002);
    check("post-rst depth", 32'(depth), 32'd1);
    check("post-rst last_in", 32'(last_in), 32'h0DD);

    // test 6: push&pop together, counter saturation
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 11'(i + 1), 11'h000, 11'h000);
    check("pp pre depth", 32'(depth), 32'd4);
    step(1'b1, 1'b1, 11'h0EE, 11'h000, 11'h000);
    check("pp depth", 32'(depth), 32'd5);
    check("pp last_in", 32'(last_in), 32'h0EE);
    step(1'b0, 1'b0, 11'h000, 11'h0EE, 11'h0EE);
    check("pp mm", 32'(mismatch), 32'd0);
    force dut.u_err_cnt.count = 16'hFFFE;
    #1;
    release dut.u_err_cnt.count;
    check("sat preload", 32'(err_count), 32'hFFFE);
    step(1'b0, 1'b1, 11'h000, 11'h0EE, 11'h0EE);
    check("sat d4", 32'(depth), 32'd4);
    step(1'b0, 1'b1, 11'h000, 11'h001, 11'h002);
    check("sat mm1", 32'(mismatch), 32'd1);
    check("sat err1", 32'(err_count), 32'hFFFF);
    step(1'b0, 1'b1, 11'h000, 11'h001, 11'h002);
    check("sat mm2", 32'(mismatch), 32'd1);
    check("sat err2", 32'(err_count), 32'hFFFF);
    step(1'b0, 1'b0, 11'h000, 11'h001, 11'h002);
    check("sat mm3", 32'(mismatch), 32'd1);
    check("sat err3", 32'(err_count), 32'hFFFF);
    check("sat depth", 32'(depth), 32'd2);
    step(1'b0, 1'b0, 11'h000, 11'h001, 11'h002);
    check("sat idle mm", 32'(mismatch), 32'd0);
    check("sat hold", 32'(err_count), 32'hFFFF);
    check("sat first_depth", 32'(first_depth), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
